// File: rtl/tx_cordic_rot.sv
// Iterative CORDIC rotator for TX symbol I/Q: quadrant pre-rotation, ITER micro-rotations, optional gain fix.
// Define TX_CORDIC_GAIN_COMP_EN to add the SCALE state (K = 0.607253 multiply); otherwise outputs carry the raw CORDIC gain.
module tx_cordic_rot #(
  parameter int WIDTH       = 16,
  parameter int WIDTH_WIRE  = 18,
  parameter int COUNT_WIDTH = 4,
  parameter int ITER        = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH_WIRE-1:0] x_in,
  input  logic signed [WIDTH_WIRE-1:0] y_in,
  input  logic signed [WIDTH-1:0]      z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WIDTH_WIRE-1:0] x_out,
  output logic signed [WIDTH_WIRE-1:0] y_out,
  output logic signed [WIDTH-1:0]      z_out,
  output logic                         busy
);

  // Two guard bits cover the ~1.65 gain on a sqrt(2)-scaled full-scale vector.
  localparam int DW = WIDTH_WIRE + 2;
  localparam logic signed [WIDTH-1:0] HALF_PI     = WIDTH'(6434);
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = WIDTH'(-6434);
  localparam logic signed [DW-1:0]    SAT_MAX     = DW'((1 << (WIDTH_WIRE - 1)) - 1);
  localparam logic signed [DW-1:0]    SAT_MIN     = DW'(-(1 << (WIDTH_WIRE - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0]   r_cnt;
  logic signed [DW-1:0]     r_x, r_y;
  logic signed [WIDTH-1:0]  r_z;
  logic                     r_out_valid;
  logic signed [WIDTH_WIRE-1:0] r_x_out, r_y_out;
  logic signed [WIDTH-1:0]  r_z_out;

  logic                     w_accept, w_last, w_d_pos;
  logic signed [DW-1:0]     w_xi, w_yi, w_xs, w_ys, w_x_rot, w_y_rot;
  logic signed [WIDTH-1:0]  w_atan, w_z_rot;

  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [COUNT_WIDTH-1:0] i);
    case (int'(i))
      0:       atan_lut = WIDTH'(3217);
      1:       atan_lut = WIDTH'(1899);
      2:       atan_lut = WIDTH'(1003);
      3:       atan_lut = WIDTH'(509);
      4:       atan_lut = WIDTH'(256);
      5:       atan_lut = WIDTH'(128);
      6:       atan_lut = WIDTH'(64);
      7:       atan_lut = WIDTH'(32);
      8:       atan_lut = WIDTH'(16);
      9:       atan_lut = WIDTH'(8);
      10:      atan_lut = WIDTH'(4);
      11:      atan_lut = WIDTH'(2);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic signed [WIDTH_WIRE-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH_WIRE-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH_WIRE-1:0];
    else                  sat = v[WIDTH_WIRE-1:0];
  endfunction

  assign w_accept = in_valid & in_ready & ce;
  assign w_last   = (r_cnt == COUNT_WIDTH'(ITER - 1));
  assign w_xi     = {{2{x_in[WIDTH_WIRE-1]}}, x_in};
  assign w_yi     = {{2{y_in[WIDTH_WIRE-1]}}, y_in};

  // One micro-rotation per cycle, direction chosen by the sign of the residual angle.
  assign w_d_pos  = ~r_z[WIDTH-1];
  assign w_xs     = r_x >>> r_cnt;
  assign w_ys     = r_y >>> r_cnt;
  assign w_atan   = atan_lut(r_cnt);
  assign w_x_rot  = w_d_pos ? (r_x - w_ys) : (r_x + w_ys);
  assign w_y_rot  = w_d_pos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_z_rot  = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

`ifdef TX_CORDIC_GAIN_COMP_EN
  localparam logic signed [15:0] K = 16'sd19898;
  logic signed [DW+15:0] w_px, w_py;
  logic signed [DW-1:0]  w_x_scl, w_y_scl;
  assign w_px    = r_x * K;
  assign w_py    = r_y * K;
  // Bit slice equals >>>15 with floor truncation; the scaled value always fits in DW.
  assign w_x_scl = w_px[DW+14:15];
  assign w_y_scl = w_py[DW+14:15];
`endif

  always_ff @(posedge clk) begin
    if (rst)     r_state <= S_IDLE;
    else if (ce) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = S_ROT;
      end
`ifdef TX_CORDIC_GAIN_COMP_EN
      S_ROT:   if (w_last) w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_DONE;
`else
      S_ROT:   if (w_last) w_state_nxt = S_DONE;
`endif
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else if (ce) begin
      if (w_accept) begin
        r_cnt <= '0;
        // Fold angles beyond +-pi/2 into the CORDIC convergence range.
        if (z_in > HALF_PI) begin
          r_x <= -w_yi;
          r_y <= w_xi;
          r_z <= z_in - HALF_PI;
        end else if (z_in < NEG_HALF_PI) begin
          r_x <= w_yi;
          r_y <= -w_xi;
          r_z <= z_in + HALF_PI;
        end else begin
          r_x <= w_xi;
          r_y <= w_yi;
          r_z <= z_in;
        end
      end else if (r_state == S_ROT) begin
        r_cnt <= r_cnt + 1'b1;
        r_x   <= w_x_rot;
        r_y   <= w_y_rot;
        r_z   <= w_z_rot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_z_out     <= '0;
    end else if (ce) begin
      r_out_valid <= (w_state_nxt == S_DONE);
`ifdef TX_CORDIC_GAIN_COMP_EN
      if (r_state == S_SCALE) begin
        r_x_out <= sat(w_x_scl);
        r_y_out <= sat(w_y_scl);
        r_z_out <= r_z;
      end
`else
      if (r_state == S_ROT && w_last) begin
        r_x_out <= sat(w_x_rot);
        r_y_out <= sat(w_y_rot);
        r_z_out <= w_z_rot;
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign z_out     = r_z_out;

endmodule

// File: doc/tx_cordic_rot.md
TX_CORDIC_ROT -- requirements
Module: tx_cordic_rot

Interface
REQ-001 Parameter WIDTH, default 16, angle width: signed Q3.12 radians.
REQ-002 Parameter WIDTH_WIRE, default 18, I/Q sample width: signed two's complement.
REQ-003 Parameter COUNT_WIDTH, default 4, iteration counter width.
REQ-004 Parameter ITER, default 12, number of micro-rotations; legal range 1..12.
REQ-005 clk  input  1  single clock; every register updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 ce  input  1  clock enable; when low, all state and outputs hold.
REQ-008 in_valid  input  1  x_in/y_in/z_in hold a valid request.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 x_in, y_in  input  WIDTH_WIRE each  symbol I/Q to rotate.
REQ-011 z_in  input  WIDTH  rotation angle, range [-pi, pi): [-12868, 12867].
REQ-012 out_valid  output  1  x_out/y_out/z_out hold a result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 x_out, y_out  output  WIDTH_WIRE each  rotated I/Q.
REQ-015 z_out  output  WIDTH  residual angle after the last iteration.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ROT, SCALE, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready & ce.
REQ-019 Pre-rotation SHALL be applied on accept, then the FSM SHALL enter ROT with cnt=0:
- z_in > 6434 (pi/2): load (x,y,z) = (-y_in, x_in, z_in-6434).
- z_in < -6434: load (y_in, -x_in, z_in+6434).
- otherwise: load the inputs unchanged.
REQ-020 Each ROT cycle i = cnt SHALL compute d = +1 if z >= 0, else -1:
- x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i.
- Shifts are arithmetic.
REQ-021 atan_i LUT (Q3.12) SHALL be 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2 for i = 0..11.
REQ-022 The x/y datapath SHALL carry WIDTH_WIRE+2 bits internally; no intermediate wrap is permitted.
REQ-023 ROT SHALL advance to SCALE when cnt == ITER-1; cnt SHALL increment by 1 per enabled cycle.
REQ-024 SCALE SHALL register x,y multiplied by K = 19898 (0.607253 in Q1.15), arithmetic >>>15 truncation, then go to DONE.
REQ-025 x_out/y_out SHALL saturate to [-2^(WIDTH_WIRE-1), 2^(WIDTH_WIRE-1)-1].
REQ-026 DONE SHALL hold out_valid=1 with stable outputs until out_ready & ce, then return to IDLE.
REQ-027 Latency: out_valid SHALL rise ITER+2 enabled cycles after the accept edge; throughput is one result per ITER+3 cycles minimum.
REQ-028 ce low in any state SHALL freeze state, cnt, datapath and outputs; no handshake completes.
REQ-029 in_valid in non-IDLE states SHALL be ignored (no queuing).
REQ-030 Outputs outside DONE SHALL retain their last result values; only out_valid qualifies them.

Reset
REQ-031 rst SHALL have priority over ce and every other input.
REQ-032 On rst, in the same edge: state=IDLE, cnt=0, x_out=y_out=z_out=0, out_valid=0, busy=0.
REQ-033 After rst, in_ready SHALL be 1 on the first cycle.
REQ-034 Reset mid-operation (ROT, SCALE or DONE) SHALL abort the operation and drop the result without emitting out_valid.

Configuration
REQ-035 Macro TX_CORDIC_GAIN_COMP_EN, when defined, SHALL enable the SCALE state and K multiply per REQ-024.
REQ-036 Without TX_CORDIC_GAIN_COMP_EN:
- SCALE and the multiplier SHALL be removed; ROT goes directly to DONE.
- Outputs carry the raw CORDIC gain (~1.6468), with saturation.
- Latency SHALL be ITER+1.

Verification
REQ-037 ITER=12, macro on: x=4096, y=0, z=0 -> x_out=4096±8, y_out=0±8, out_valid 14 cycles after accept.
REQ-038 x=4096, y=0, z=6434 (pi/2) -> x_out=0±8, y_out=4096±8.
REQ-039 x=4096, y=0, z=-12868 (-pi, pre-rotation path) -> x_out=-4096±8, y_out=0±8; |z_out| <= 4.
REQ-040 x=4096, y=0, z=3217 (pi/4) -> x_out=y_out=2896±8.
REQ-041 Back-pressure and control:
- out_ready low 5 cycles: outputs stable, in_ready=0.
- ce low 3 cycles mid-ROT: latency extends by exactly 3.
- rst in ROT: next cycle out_valid=0, in_ready=1.
REQ-042 Macro off: x=4096, y=0, z=0 -> x_out=6745±8, y_out=0±8, out_valid 13 cycles after accept.
